control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, 32'h0000_0010: PC value loaded on a trap.
REQ-003 Clock, one domain; reset asynchronous, active-low; all state changes on clk rising edge.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 opcode  in  7  inst[6:0] of the instruction register.
REQ-007 funct3  in  3  inst[14:12].
REQ-008 bit20  in  1  inst[20]; 0 = ECALL, 1 = EBREAK when SYSTEM and funct3 = 0.
REQ-009 branch_taken  in  1  datapath branch-compare result, valid in EXEC and WB.
REQ-010 next_pc  in  32  datapath jump/branch target, valid in WB.
REQ-011 mem_ready  in  1  memory accepts/completes the current request.
REQ-012 mem_req  out  1  memory request.
REQ-013 mem_we  out  1  1 = store, 0 = read.
REQ-014 mem_addr_sel  out  1  0 = address from pc, 1 = address from ALU.
REQ-015 ir_we  out  1  instruction register load strobe.
REQ-016 rf_we  out  1  register-file write strobe.
REQ-017 pc  out  32  current program counter.
REQ-018 state  out  3  current state encoding.
REQ-019 trap  out  1  one-cycle trap pulse.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 go to FETCH on the next edge.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0; ir_we = mem_ready; on mem_ready go to DECODE, else stay.
REQ-022 DECODE: one cycle; illegal opcode or (SYSTEM, funct3=0) goes to TRAP, else EXEC.
REQ-023 Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011; all others are illegal.
REQ-024 EXEC: one cycle; LOAD (0000011) or STORE (0100011) goes to MEM, else WB.
REQ-025 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; on mem_ready go to WB, else stay.
REQ-026 Transfer occurs on the edge where mem_req and mem_ready are both 1; mem_we and mem_addr_sel are held stable while mem_req=1.
REQ-027 WB: one cycle; rf_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and SYSTEM with funct3 != 0; rf_we=0 otherwise; next state FETCH.
REQ-028 PC update at end of WB: JAL/JALR set pc to next_pc; BRANCH sets pc to next_pc if branch_taken, else pc+4; all others set pc to pc+4, modulo 2^32.
REQ-029 TRAP: trap=1 for exactly one cycle, pc set to TRAP_VEC, rf_we=0, mem_req=0; next state FETCH.
REQ-030 Outputs not listed for a state are 0; all outputs decode from registered state only, with no combinational path from opcode to mem_req.
REQ-031 Latency with mem_ready held high: ALU/jump/branch/FENCE 4 cycles; LOAD/STORE 5 cycles; trap 3 cycles to the next FETCH.
REQ-032 mem_ready while mem_req=0 is ignored.
REQ-033 pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-034 rst_n=0 forces state=FETCH and pc=RESET_PC immediately, asynchronously; trap, ir_we, rf_we are 0 while in reset.
REQ-035 A reset asserted during FETCH or MEM abandons the transfer, with no ir_we or rf_we pulse; the first request after release is a fetch at RESET_PC.
REQ-036 After rst_n deasserts, the first rising edge evaluates FETCH normally.

Verification
REQ-037 ADDI (0010011), mem_ready=1 always -> states 0,1,2,4,0; rf_we high only in cycle 4; pc 0->4.
REQ-038 LW, mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, mem_addr_sel=1, mem_we=0; then WB with rf_we=1; pc=4.
REQ-039 SW -> MEM with mem_we=1; WB with rf_we=0; pc=4.
REQ-040 BEQ at pc=8, next_pc=32'h40: branch_taken=1 -> pc=32'h40; branch_taken=0 -> pc=32'hC; rf_we never set.
REQ-041 Opcode 7'h7F, then ECALL (1110011, funct3=0, bit20=0) -> each does DECODE then TRAP with a 1-cycle trap pulse, pc=32'h10, rf_we=0; CSRRW (funct3=1) instead writes rd and gives pc+4.
REQ-042 rst_n pulled low mid-MEM of a store -> mem_req drops without waiting for a clock, pc=0, state=0; after release, fetch from address 0 with no register write.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory and write-back
// stepping plus program-counter management and trap entry.
module control_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        bit20,
    input  logic        branch_taken,
    input  logic [31:0] next_pc,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        trap
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        is_ls_q, is_store_q, wr_rd_q, is_jump_q, is_branch_q;

    logic legal, wr_rd, do_trap;
    logic is_ls, is_store, is_jump, is_branch;

    // ECALL and EBREAK trap identically, so bit20 carries no information here.
    logic unused_bit20;
    assign unused_bit20 = bit20;

    always_comb begin
        legal = 1'b1;
        wr_rd = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpImm, OpOp: wr_rd = 1'b1;
            OpBranch, OpStore, OpFence: wr_rd = 1'b0;
            OpSystem: wr_rd = (funct3 != 3'b000);
            default: legal = 1'b0;
        endcase
    end

    assign do_trap   = !legal || (opcode == OpSystem && funct3 == 3'b000);
    assign is_ls     = (opcode == OpLoad) || (opcode == OpStore);
    assign is_store  = (opcode == OpStore);
    assign is_jump   = (opcode == OpJal) || (opcode == OpJalr);
    assign is_branch = (opcode == OpBranch);

    // Instruction class is captured in DECODE so later outputs depend only on registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            is_ls_q     <= 1'b0;
            is_store_q  <= 1'b0;
            wr_rd_q     <= 1'b0;
            is_jump_q   <= 1'b0;
            is_branch_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) state_q <= StDecode;
                end
                StDecode: begin
                    is_ls_q     <= is_ls;
                    is_store_q  <= is_store;
                    wr_rd_q     <= wr_rd;
                    is_jump_q   <= is_jump;
                    is_branch_q <= is_branch;
                    if (do_trap) begin
                        state_q <= StTrap;
                        pc_q    <= TRAP_VEC;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    state_q <= is_ls_q ? StMem : StWb;
                end
                StMem: begin
                    if (mem_ready) state_q <= StWb;
                end
                StWb: begin
                    if (is_jump_q || (is_branch_q && branch_taken)) begin
                        pc_q <= next_pc;
                    end else begin
                        pc_q <= pc_q + 32'd4;
                    end
                    state_q <= StFetch;
                end
                StTrap: begin
                    state_q <= StFetch;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    // Gating with rst_n drops any in-flight request the moment reset asserts.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        trap         = 1'b0;
        if (rst_n) begin
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                StMem: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store_q;
                end
                StWb:    rf_we = wr_rd_q;
                StTrap:  trap  = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-cycle expected output records are queued as
// stimulus is planned and compared against the DUT's sampled outputs.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'b0010011;
    logic [2:0]  funct3 = 3'b000;
    logic        bit20 = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, rf_we, trap;
    logic [31:0] pc;
    logic [2:0]  state;

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .bit20(bit20),
        .branch_taken(branch_taken), .next_pc(next_pc), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .rf_we(rf_we), .pc(pc), .state(state), .trap(trap)
    );

    always #5 clk = ~clk;

    // Flag order: {mem_req, mem_we, mem_addr_sel, ir_we, rf_we, trap}
    localparam logic [5:0] FRdy   = 6'b100100;
    localparam logic [5:0] FWait  = 6'b100000;
    localparam logic [5:0] FNone  = 6'b000000;
    localparam logic [5:0] FLoad  = 6'b101000;
    localparam logic [5:0] FStore = 6'b111000;
    localparam logic [5:0] FRf    = 6'b000010;
    localparam logic [5:0] FTrap  = 6'b000001;

    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [40:0] ex(input logic [2:0] s, input logic [31:0] p,
                                       input logic [5:0] f);
        return {s, p, f};
    endfunction

    function automatic logic [40:0] sample();
        return {state, pc, mem_req, mem_we, mem_addr_sel, ir_we, rf_we, trap};
    endfunction

    task automatic set_inst(input logic [6:0] op, input logic [2:0] f3, input logic b20,
                            input logic tk, input logic [31:0] tgt);
        opcode = op; funct3 = f3; bit20 = b20; branch_taken = tk; next_pc = tgt;
    endtask

    // Drive mem_ready per cycle and record the outputs one tick after the falling edge.
    task automatic run(input int n, input logic [15:0] rdy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = rdy[i];
            #1;
            obs_q.push_back(sample());
        end
    endtask

    // Four-state ALU-style instruction: F D E W, then a stalled FETCH at the new pc.
    task automatic plan_short(input logic [31:0] p, input logic [5:0] wb, input logic [31:0] np);
        exp_q.push_back(ex(3'd0, p, FRdy));
        exp_q.push_back(ex(3'd1, p, FNone));
        exp_q.push_back(ex(3'd2, p, FNone));
        exp_q.push_back(ex(3'd4, p, wb));
        exp_q.push_back(ex(3'd0, np, FWait));
    endtask

    task automatic plan_trap(input logic [31:0] p);
        exp_q.push_back(ex(3'd0, p, FRdy));
        exp_q.push_back(ex(3'd1, p, FNone));
        exp_q.push_back(ex(3'd5, 32'h10, FTrap));
        exp_q.push_back(ex(3'd0, 32'h10, FWait));
    endtask

    task automatic test_reset();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'b0010011, 3'b000, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(ex(3'd0, 32'h0, FNone));
        run(3, 16'b011);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_alu();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'b0010011, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEC);
        plan_short(32'h0, FRf, 32'h4);
        run(5, 16'b01111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL addi[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_load_store();
        logic [40:0] e, o;
        int k = 0;
        // LW with two wait cycles in MEM; mem_ready low in DECODE/EXEC must not matter.
        set_inst(7'b0000011, 3'b010, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(ex(3'd0, 32'h4, FRdy));
        exp_q.push_back(ex(3'd1, 32'h4, FNone));
        exp_q.push_back(ex(3'd2, 32'h4, FNone));
        for (int i = 0; i < 3; i++) exp_q.push_back(ex(3'd3, 32'h4, FLoad));
        exp_q.push_back(ex(3'd4, 32'h4, FRf));
        exp_q.push_back(ex(3'd0, 32'h8, FWait));
        run(8, 16'b0110_0001);
        set_inst(7'b0100011, 3'b010, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(ex(3'd0, 32'h8, FRdy));
        exp_q.push_back(ex(3'd1, 32'h8, FNone));
        exp_q.push_back(ex(3'd2, 32'h8, FNone));
        exp_q.push_back(ex(3'd3, 32'h8, FStore));
        exp_q.push_back(ex(3'd4, 32'h8, FNone));
        exp_q.push_back(ex(3'd0, 32'hC, FWait));
        run(6, 16'b011111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ldst[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_branch_jump();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'b1100011, 3'b000, 1'b0, 1'b1, 32'h40);
        plan_short(32'hC, FNone, 32'h40);
        run(5, 16'b01111);
        set_inst(7'b1100011, 3'b000, 1'b0, 1'b0, 32'h40);
        plan_short(32'h40, FNone, 32'h44);
        run(5, 16'b01111);
        set_inst(7'b1101111, 3'b000, 1'b0, 1'b0, 32'h100);
        plan_short(32'h44, FRf, 32'h100);
        run(5, 16'b01111);
        set_inst(7'b0001111, 3'b000, 1'b0, 1'b1, 32'h800);
        plan_short(32'h100, FNone, 32'h104);
        run(5, 16'b01111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL brjmp[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_trap();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'h7F, 3'b000, 1'b0, 1'b0, 32'h0);
        plan_trap(32'h104);
        run(4, 16'b0111);
        set_inst(7'b1110011, 3'b001, 1'b0, 1'b0, 32'h0);
        plan_short(32'h10, FRf, 32'h14);
        run(5, 16'b01111);
        set_inst(7'b1110011, 3'b000, 1'b0, 1'b0, 32'h0);
        plan_trap(32'h14);
        run(4, 16'b0111);
        set_inst(7'b1110011, 3'b000, 1'b1, 1'b0, 32'h0);
        plan_trap(32'h10);
        run(4, 16'b0111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL trap[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_wrap();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'b1100111, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFC);
        plan_short(32'h10, FRf, 32'hFFFF_FFFC);
        run(5, 16'b01111);
        set_inst(7'b0010011, 3'b000, 1'b0, 1'b0, 32'h0);
        plan_short(32'hFFFF_FFFC, FRf, 32'h0);
        run(5, 16'b01111);
        set_inst(7'b0110111, 3'b000, 1'b0, 1'b0, 32'h0);
        plan_short(32'h0, FRf, 32'h4);
        run(5, 16'b01111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'b0100011, 3'b010, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(ex(3'd0, 32'h4, FRdy));
        exp_q.push_back(ex(3'd1, 32'h4, FNone));
        exp_q.push_back(ex(3'd2, 32'h4, FNone));
        exp_q.push_back(ex(3'd3, 32'h4, FStore));
        run(4, 16'b0001);
        // Mid-cycle reset: outputs must change before any clock edge.
        #2 rst_n = 1'b0;
        #1 obs_q.push_back(sample());
        exp_q.push_back(ex(3'd0, 32'h0, FNone));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(ex(3'd0, 32'h0, FRdy));
        exp_q.push_back(ex(3'd1, 32'h0, FNone));
        exp_q.push_back(ex(3'd2, 32'h0, FNone));
        exp_q.push_back(ex(3'd3, 32'h0, FStore));
        exp_q.push_back(ex(3'd4, 32'h0, FNone));
        exp_q.push_back(ex(3'd0, 32'h4, FWait));
        run(6, 16'b011111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rstmem[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] e, o;
        int k = 0;
        set_inst(7'b0110011, 3'b000, 1'b0, 1'b0, 32'h0);
        for (int j = 0; j < 2; j++) begin
            exp_q.push_back(ex(3'd0, 32'h4 + 32'(4 * j), FRdy));
            exp_q.push_back(ex(3'd1, 32'h4 + 32'(4 * j), FNone));
            exp_q.push_back(ex(3'd2, 32'h4 + 32'(4 * j), FNone));
            exp_q.push_back(ex(3'd4, 32'h4 + 32'(4 * j), FRf));
        end
        exp_q.push_back(ex(3'd0, 32'hC, FWait));
        run(9, 16'b0_1111_1111);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got st=%0d pc=%h fl=%b, want st=%0d pc=%h fl=%b",
                         k, o[40:38], o[37:6], o[5:0], e[40:38], e[37:6], e[5:0]);
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch_jump();
        test_trap();
        test_wrap();
        test_reset_mid_mem();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
